// File: rtl/mode_counter_pkg.sv
// rtl/mode_counter_pkg.sv - mode encodings and FSM state type for mode_counter
package mode_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/mode_counter_prescaler.sv
// rtl/mode_counter_prescaler.sv - tick divider by presc+1 over enabled cycles
module mode_counter_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;
    logic [PRESC_W-1:0] ratio;

    assign tick = en && (cnt == ratio);

    // ratio is resampled only at a reload so a presc change never truncates a running period
    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            cnt   <= '0;
            ratio <= presc;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - up/down counter with wrap/sat/one-shot modes and terminal-count pulse
// Optional tick prescaler enabled by MODE_COUNTER_PRESCALE_EN.
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MOD     = 256,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               dir,
    input  logic [1:0]         mode,
    input  logic               wr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   out,
    output logic               tc,
    output logic               done
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] out_n;
    logic             tc_n;
    logic             tick;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] stepped;

`ifdef MODE_COUNTER_PRESCALE_EN
    mode_counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (wr),
        .presc (presc),
        .tick  (tick)
    );
`else
    logic unused_presc;
    assign unused_presc = ^presc;
    assign tick = en;
`endif

    assign term = dir ? TOP : '0;

    always_comb begin
        if (dir) stepped = (out == TOP) ? '0 : out + 1'b1;
        else     stepped = (out == '0) ? TOP : out - 1'b1;
    end

    always_comb begin
        out_n   = out;
        tc_n    = 1'b0;
        state_n = state;
        if (wr) begin
            out_n   = (wr_data > TOP) ? TOP : wr_data;
            state_n = RUN;
        end else if (state == HOLD) begin
            if (mode != MODE_ONESHOT) state_n = RUN;
        end else if (tick) begin
            unique case (mode)
                MODE_SAT: begin
                    if (out != term) begin
                        out_n = stepped;
                        tc_n  = (stepped == term);
                    end
                end
                MODE_ONESHOT: begin
                    out_n = stepped;
                    tc_n  = (stepped == term);
                    if (stepped == term) state_n = HOLD;
                end
                default: begin
                    out_n = stepped;
                    tc_n  = (stepped == term);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            out   <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_n;
            out   <= out_n;
            tc    <= tc_n;
        end
    end

    assign done = (state == HOLD);

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised successor to the team's 8-bit loadable counter. Generalises width and modulus, adds up/down direction, wrap/saturate/one-shot modes, a terminal-count pulse and an optional tick prescaler. Used as a general timer/event counter next to other lib blocks, clocked from the system clock.

## Interface

Parameters:
- WIDTH, 8, counter width in bits
- MOD, 256, count modulus; legal values 2..2**WIDTH; terminal values are 0 and MOD-1
- PRESC_W, 4, prescaler reload width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  count enable; one step per enabled tick
- dir  in  1  1 = up, 0 = down
- mode  in  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 treated as WRAP
- wr  in  1  load strobe
- wr_data  in  WIDTH  load value
- presc  in  PRESC_W  prescaler reload; divide ratio presc+1
- out  out  WIDTH  current count, registered
- tc  out  1  terminal-count pulse, registered
- done  out  1  high while one-shot is halted

## Operation

- Priority per cycle: rst > wr > count step.
- Load: out <= min(wr_data, MOD-1); independent of en; clears prescaler; forces state RUN; tc <= 0.
- Step: occurs when state RUN and tick=1 (tick = en, or prescaler output, see Configuration).
- Terminal value T = MOD-1 if dir=1, 0 if dir=0.
- WRAP: up from MOD-1 -> 0; down from 0 -> MOD-1; otherwise ±1.
- SAT: at T, out holds; otherwise ±1.
- ONESHOT: ±1; on reaching T, state -> HOLD; in HOLD no steps.
- FSM: RUN, HOLD. RUN -> HOLD only in ONESHOT when a step lands on T. HOLD -> RUN on wr, on rst, or when mode leaves ONESHOT. done = (state == HOLD).
- tc = 1 for exactly one cycle, the cycle in which out first holds T as a result of a step. No tc from loads, from SAT holding at T, or in HOLD.
- dir/mode changes take effect on the next step; no pipeline.
- Arithmetic in WIDTH bits; MOD = 2**WIDTH gives natural binary wrap.

## Timing

- Reset values: out = 0, tc = 0, done = 0, state RUN, prescaler count 0.
- Latency: step/load visible on out the cycle after the enabling edge; tc and done registered, aligned with the out value they describe.
- rst asserted mid-count or in HOLD: outputs reset next cycle regardless of wr/en.
- wr and tick same cycle: load wins, no step, no tc.
- Direction reversal while at T in SAT: counting resumes next tick.
- en low: out, tc (0 after its pulse), done, state held; prescaler frozen.

## Configuration

- Macro MODE_COUNTER_PRESCALE_EN.
- Defined: prescaler counts enabled cycles 0..presc, asserts tick on the cycle it equals presc, then reloads 0; presc=0 gives tick = en. presc change takes effect at the next reload.
- Undefined: no prescaler logic, tick = en, presc port present but ignored.

## Structure

- Shared package mode_counter_pkg: mode encoding constants (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and state typedef (RUN, HOLD).
- One sub-module, mode_counter_prescaler (clk, rst, en, clr, presc -> tick), instantiated only under MODE_COUNTER_PRESCALE_EN.
- Top owns FSM, count register, tc/done registers.

## Test plan

Bench WIDTH=8, MOD=100, PRESC_W=4.
- rst for 10 cycles then en=1, dir=1, WRAP -> out 0,1,...,99,0,1; tc high only in the cycle out=99; out=0 during reset.
- wr=1, wr_data=55 with en=0 -> out=55 next cycle; wr_data=200 -> out=99; wr together with en -> loaded value, no increment.
- SAT, dir=0, load 2 -> out 1,0,0,0; single tc pulse at out=0; then dir=1 -> out 1.
- ONESHOT, dir=1, load 97 -> 98,99 then hold at 99, done=1, tc one pulse; wr_data=10 -> out 10, done 0, counting resumes 11.
- rst, wr and en all high at out=50 -> out=0, tc=0, done=0 next cycle.
- With MODE_COUNTER_PRESCALE_EN, presc=3, WRAP up from 0 -> out increments every 4th enabled cycle; en low 5 cycles mid-period -> phase preserved; without macro same stimulus -> increments every cycle.
